tt_pin_host: RTL and testbench
==============================

# tt_pin_host

Host-side transaction engine for the TinyTapeout user-project pin interface. It drives the DUT-facing `ui_in`/`uio_in`/`ena`/`rst_n` pins and captures `uo_out`/`uio_out`/`uio_oe`, so a tile can be exercised from a byte-stream command port. It converts each accepted command byte into a 4-phase req/ack exchange on the pins and returns the DUT response byte on a valid/ready response port. It sits between a board/FPGA controller or bench sequencer and one `tt_um_*` instance.

## Interface
- `RST_CYCLES`, 8: cycles `pin_rst_n` is held low after host reset releases (1..255).
- `SYNC_STAGES`, 2: flop stages on the ack input (2..3).
- `TIMEOUT`, 1023: max cycles waiting on any ack edge, when the timeout feature is compiled in.
- `clk` in 1: single clock, also forwarded as the DUT clock by the board.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1, `cmd_ready` out 1, `cmd_data` in 8: command byte stream.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_data` out 8, `rsp_err` out 1: response stream.
- `busy` out 1: high whenever the FSM is not IDLE or DUT reset is in progress.
- `pin_ena` out 1: DUT enable.
- `pin_rst_n` out 1: DUT active-low reset.
- `pin_ui_in` out 8: DUT dedicated inputs, carrying the command data.
- `pin_uio_in` out 8: bit 0 = req; bits 7:1 are driven 0.
- `pin_uo_out` in 8: DUT response data.
- `pin_uio_out` in 8, `pin_uio_oe` in 8: bit 1 = ack, valid only when `pin_uio_oe[1]`=1.

## Operation
- Qualified ack = `pin_uio_out[1] & pin_uio_oe[1]`, passed through the synchronizer (`ack_s`).
- States:
  - RESET: `pin_rst_n`=0 for `RST_CYCLES` cycles after `rst` falls, then go to IDLE.
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cmd_data` into `pin_ui_in` and go to SETUP.
  - SETUP: exactly 1 cycle of data settle with req low, then go to REQ.
  - REQ: req=1; wait for `ack_s`=1, then go to CAPTURE.
  - CAPTURE: 1 cycle. Register `pin_uo_out` into `rsp_data`, set `rsp_err`=0, drop req, go to RELEASE.
  - RELEASE: wait for `ack_s`=0, then go to RESP.
  - RESP: `rsp_valid`=1; hold `rsp_data`/`rsp_err` stable until `rsp_ready`, then go to IDLE.
- `pin_ui_in` holds the last command byte between transactions and never changes outside IDLE→SETUP.
- `cmd_ready` is 0 in every state except IDLE, so there is exactly one outstanding transaction.
- An ack that is already high on entry to REQ is accepted (level-sensitive). `ack_s` high in SETUP is ignored.
- `pin_ena`=1 from the first cycle after `rst` falls.

## Timing
- Reset values while `rst`=1:
  - `pin_rst_n`=0, `pin_ena`=0, `pin_ui_in`=0, `pin_uio_in`=0
  - `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=1
- Command accepted at edge N: `pin_ui_in` is valid after N; req rises after N+1.
- DUT ack rising before edge M is seen as `ack_s` at M+`SYNC_STAGES`−1; CAPTURE follows at the next edge.
- Minimum command-to-`rsp_valid` latency with a zero-wait DUT is 5+2·`SYNC_STAGES` cycles.
- `rst` asserted mid-transaction aborts immediately to RESET: req drops asynchronously, any pending response is discarded, and the DUT is re-reset.
- `rsp_ready` held high gives back-to-back throughput; the next `cmd_ready` arrives the cycle after the response handshake.

## Configuration
- `TT_PIN_HOST_TIMEOUT_EN` defined:
  - A saturating counter runs in REQ and in RELEASE, cleared on each state entry.
  - Reaching `TIMEOUT` goes to RESP with `rsp_err`=1 and `rsp_data`=8'hFF, and req is dropped.
  - A REQ timeout skips RELEASE.
- Undefined: no counter; REQ and RELEASE wait indefinitely, and `rsp_err` is constant 0.

## Structure
- `tt_pin_host_pkg`:
  - state enum `host_state_t` (RESET, IDLE, SETUP, REQ, CAPTURE, RELEASE, RESP)
  - `REQ_BIT`=0, `ACK_BIT`=1
  - `TIMEOUT_RSP`=8'hFF
- Sub-module `tt_pin_sync`: parameterized `SYNC_STAGES` flop chain, async-reset to 0, instantiated once for ack.

## Test plan
- Reset release with `RST_CYCLES`=8 → `pin_rst_n` low exactly 8 cycles, then `cmd_ready`=1 and `pin_ena`=1.
- Command 8'hA5; responder acks after 3 cycles with `uo_out`=8'h3C → `pin_ui_in`=8'hA5, `rsp_data`=8'h3C, `rsp_err`=0, req low before RESP.
- Ack driven but `uio_oe[1]`=0 → no CAPTURE; with the macro defined, timeout gives `rsp_err`=1 and `rsp_data`=8'hFF after 1023 cycles in REQ.
- `rsp_ready` held low 10 cycles → `rsp_valid`/`rsp_data` stable, `cmd_ready`=0, `cmd_valid` ignored throughout.
- `rst` pulsed while in REQ → req=0 immediately, `rsp_valid` never asserts, DUT reset sequence repeats.
- 16 back-to-back commands 0x00..0x0F with an echoing responder → 16 responses in order, each matching its command.

Source files
------------

// File: rtl/tt_pin_host_pkg.sv
// -----------------------------------------------------------------------------
// tt_pin_host_pkg
// Shared types and constants for the TinyTapeout pin-interface host engine.
//   host_state_t : transaction FSM states
//   REQ_BIT      : req position on uio_in
//   ACK_BIT      : ack position on uio_out / uio_oe
//   TIMEOUT_RSP  : response byte returned when the DUT never answers
// -----------------------------------------------------------------------------
package tt_pin_host_pkg;

    typedef enum logic [2:0] {
        RESET,
        IDLE,
        SETUP,
        REQ,
        CAPTURE,
        RELEASE,
        RESP
    } host_state_t;

    localparam int          REQ_BIT     = 0;
    localparam int          ACK_BIT     = 1;
    localparam logic [7:0]  TIMEOUT_RSP = 8'hFF;

endpackage

// File: rtl/tt_pin_sync.sv
// -----------------------------------------------------------------------------
// tt_pin_sync
// Plain flop-chain synchronizer for one asynchronous level input.
// Ports:
//   clk  : sampling clock
//   rst  : asynchronous active-high reset, clears every stage to 0
//   d_i  : asynchronous input level
//   q_o  : synchronized level, SYNC_STAGES cycles of latency
// -----------------------------------------------------------------------------
module tt_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/tt_pin_host.sv
// -----------------------------------------------------------------------------
// tt_pin_host
// Host-side engine that turns a byte command stream into 4-phase req/ack
// exchanges on a TinyTapeout tile's pins and returns the DUT's answer byte.
//
// Parameters:
//   RST_CYCLES  : cycles pin_rst_n is held low after rst releases (1..255)
//   SYNC_STAGES : synchronizer depth on the ack input (2..3)
//   TIMEOUT     : max cycles waiting on an ack edge (timeout build only)
//
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_data   : command byte stream in
//   rsp_valid/rsp_ready/rsp_data   : response byte stream out
//   rsp_err                        : response came from a timeout
//   busy                           : FSM not IDLE (includes DUT reset)
//   pin_ena, pin_rst_n             : DUT enable and active-low reset
//   pin_ui_in                      : DUT inputs, last command byte
//   pin_uio_in                     : bit 0 = req, other bits 0
//   pin_uo_out                     : DUT response data
//   pin_uio_out, pin_uio_oe        : bit 1 = ack, qualified by its oe bit
//
// Build option:
//   TT_PIN_HOST_TIMEOUT_EN : when defined, REQ and RELEASE give up after
//                            TIMEOUT cycles and answer with rsp_err=1 and
//                            rsp_data=8'hFF. Otherwise they wait forever.
// -----------------------------------------------------------------------------
module tt_pin_host
    import tt_pin_host_pkg::*;
#(
    parameter int RST_CYCLES  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic       pin_ena,
    output logic       pin_rst_n,
    output logic [7:0] pin_ui_in,
    output logic [7:0] pin_uio_in,
    input  logic [7:0] pin_uo_out,
    input  logic [7:0] pin_uio_out,
    input  logic [7:0] pin_uio_oe
);

    host_state_t state_q;
    logic [7:0]  rst_cnt_q;
    logic        pin_rst_n_q;
    logic        pin_ena_q;
    logic [7:0]  ui_q;
    logic        req_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        busy_q;

    logic        ack_qual;
    logic        ack_s;

    // Ack only counts while the DUT actually drives that pin.
    assign ack_qual = pin_uio_out[ACK_BIT] & pin_uio_oe[ACK_BIT];

    tt_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ack_qual),
        .q_o (ack_s)
    );

    // Remaining uio bits are not part of the protocol.
    logic unused_uio;
    assign unused_uio = ^{pin_uio_out[7:2], pin_uio_out[0],
                          pin_uio_oe[7:2],  pin_uio_oe[0]};

`ifdef TT_PIN_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;
    logic            to_expired;
    logic            rsp_err_q;

    // Counter only runs in the two wait states; every other state parks it
    // at zero, so each entry into REQ or RELEASE starts a fresh count.
    // NOTE: combinational blocks assign a default first so no path leaves
    // the output unassigned, which would otherwise infer a latch.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == REQ || state_q == RELEASE) begin
            to_cnt_d = (to_cnt_q == TO_W'(TIMEOUT)) ? to_cnt_q : to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // Expires on the TIMEOUT-th cycle spent in the wait state.
    assign to_expired = (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET;
            rst_cnt_q   <= '0;
            pin_rst_n_q <= 1'b0;
            pin_ena_q   <= 1'b0;
            ui_q        <= '0;
            req_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b1;
`ifdef TT_PIN_HOST_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            pin_ena_q <= 1'b1;
            unique case (state_q)
                RESET: begin
                    // DUT sees pin_rst_n low on RST_CYCLES rising edges.
                    if (rst_cnt_q == 8'(RST_CYCLES - 1)) begin
                        state_q     <= IDLE;
                        pin_rst_n_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 8'd1;
                    end
                end

                IDLE: begin
                    if (cmd_valid) begin
                        ui_q        <= cmd_data;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SETUP;
                    end
                end

                // One settle cycle with req low; a stale ack here is ignored.
                SETUP: begin
                    req_q   <= 1'b1;
                    state_q <= REQ;
                end

                REQ: begin
                    if (ack_s) begin
                        state_q <= CAPTURE;
                    end
`ifdef TT_PIN_HOST_TIMEOUT_EN
                    else if (to_expired) begin
                        // Nothing to release: go straight to the response.
                        req_q       <= 1'b0;
                        rsp_data_q  <= TIMEOUT_RSP;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
`endif
                end

                CAPTURE: begin
                    rsp_data_q <= pin_uo_out;
`ifdef TT_PIN_HOST_TIMEOUT_EN
                    rsp_err_q  <= 1'b0;
`endif
                    req_q      <= 1'b0;
                    state_q    <= RELEASE;
                end

                RELEASE: begin
                    if (!ack_s) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
`ifdef TT_PIN_HOST_TIMEOUT_EN
                    else if (to_expired) begin
                        rsp_data_q  <= TIMEOUT_RSP;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
`endif
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= RESET;
                end
            endcase
        end
    end

    always_comb begin
        pin_uio_in          = '0;
        pin_uio_in[REQ_BIT] = req_q;
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign pin_ena   = pin_ena_q;
    assign pin_rst_n = pin_rst_n_q;
    assign pin_ui_in = ui_q;

endmodule

// File: tb/tb_tt_pin_host.sv
// -----------------------------------------------------------------------------
// tb_tt_pin_host
// Directed bench for tt_pin_host. A scripted responder drives ack/uo_out; it
// can also be switched to a zero-wait echo mode (ack follows req, uo_out
// mirrors ui_in). Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_tt_pin_host;

    localparam int RST_CYCLES  = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 1023;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       pin_ena;
    logic       pin_rst_n;
    logic [7:0] pin_ui_in;
    logic [7:0] pin_uio_in;
    logic [7:0] pin_uo_out;
    logic [7:0] pin_uio_out;
    logic [7:0] pin_uio_oe;

    // Responder controls.
    logic       comb_ack;
    logic       echo;
    logic       tb_ack;
    logic       tb_oe;
    logic [7:0] tb_uo;

    assign pin_uio_out = {6'b0, (comb_ack ? pin_uio_in[0] : tb_ack), 1'b0};
    assign pin_uio_oe  = {6'b0, tb_oe, 1'b0};
    assign pin_uo_out  = echo ? pin_ui_in : tb_uo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tt_pin_host #(
        .RST_CYCLES  (RST_CYCLES),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .pin_ena     (pin_ena),
        .pin_rst_n   (pin_rst_n),
        .pin_ui_in   (pin_ui_in),
        .pin_uio_in  (pin_uio_in),
        .pin_uo_out  (pin_uo_out),
        .pin_uio_out (pin_uio_out),
        .pin_uio_oe  (pin_uio_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Releases rst and counts the edges until pin_rst_n goes high.
    task automatic reset_release(input string tag);
        int n;
        bit saw_rsp;
        n       = 0;
        saw_rsp = 1'b0;
        rst     = 1'b0;
        for (int i = 0; i < RST_CYCLES + 10; i++) begin
            step(1);
            n++;
            if (rsp_valid) saw_rsp = 1'b1;
            if (n == 1) check({tag, "_ena_first_cycle"}, 32'(pin_ena), 32'd1);
            if (pin_rst_n) break;
        end
        check({tag, "_rstn_low_edges"}, 32'(n), 32'(RST_CYCLES));
        check({tag, "_no_rsp_in_reset"}, 32'(saw_rsp), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_ena"}, 32'(pin_ena), 32'd1);
    endtask

    // Presents a command and returns just after the accepting edge.
    task automatic send_cmd(input string tag, input logic [7:0] data);
        int n;
        n         = 0;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            step(1);
            n++;
        end
        check({tag, "_accept_in_time"}, 32'(cmd_ready), 32'd1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < max) begin
            step(1);
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  n;
        int  tx;
        int  rx;
        bit  fire_cmd;
        bit  fire_rsp;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        comb_ack  = 1'b0;
        echo      = 1'b0;
        tb_ack    = 1'b0;
        tb_oe     = 1'b1;
        tb_uo     = 8'h00;

        // ---- Reset values while rst is held -------------------------------
        step(3);
        check("rst_pin_rst_n",  32'(pin_rst_n),  32'd0);
        check("rst_pin_ena",    32'(pin_ena),    32'd0);
        check("rst_pin_ui_in",  32'(pin_ui_in),  32'h00);
        check("rst_pin_uio_in", 32'(pin_uio_in), 32'h00);
        check("rst_cmd_ready",  32'(cmd_ready),  32'd0);
        check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        check("rst_rsp_data",   32'(rsp_data),   32'h00);
        check("rst_rsp_err",    32'(rsp_err),    32'd0);
        check("rst_busy",       32'(busy),       32'd1);

        // ---- Reset release ------------------------------------------------
        reset_release("por");

        // ---- Command A5, ack 3 cycles after req, uo_out = 3C -------------
        send_cmd("a5", 8'hA5);
        check("a5_ui_in",       32'(pin_ui_in),  32'hA5);
        check("a5_setup_req_lo", 32'(pin_uio_in), 32'h00);
        check("a5_cmd_ready_lo", 32'(cmd_ready),  32'd0);
        step(1);
        check("a5_req_hi",      32'(pin_uio_in), 32'h01);
        step(3);
        check("a5_still_req",   32'(pin_uio_in), 32'h01);
        tb_uo  = 8'h3C;
        tb_ack = 1'b1;
        n = 0;
        while (pin_uio_in[0] && n < 20) begin
            step(1);
            n++;
        end
        check("a5_req_dropped", 32'(pin_uio_in[0]), 32'd0);
        check("a5_req_low_before_resp", 32'(rsp_valid), 32'd0);
        tb_uo  = 8'h00;   // captured value must not follow uo_out any more
        tb_ack = 1'b0;
        wait_rsp(20, cyc);
        check("a5_rsp_valid",   32'(rsp_valid),  32'd1);
        check("a5_rsp_data",    32'(rsp_data),   32'h3C);
        check("a5_rsp_err",     32'(rsp_err),    32'd0);
        check("a5_req_lo_resp", 32'(pin_uio_in), 32'h00);
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        check("a5_cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("a5_rsp_valid_drop",  32'(rsp_valid), 32'd0);
        check("a5_ui_held",         32'(pin_ui_in), 32'hA5);

        // ---- Zero-wait latency, then 10-cycle response stall -------------
        comb_ack = 1'b1;
        echo     = 1'b1;
        send_cmd("lat", 8'h5A);
        wait_rsp(40, cyc);
        // rsp_valid appears after edge N+4+2S and is first consumed at N+5+2S.
        check("lat_cmd_to_rsp", 32'(cyc + 1), 32'(5 + 2 * SYNC_STAGES));
        cmd_valid = 1'b1;
        cmd_data  = 8'h77;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("stall%0d_rsp_data", i),  32'(rsp_data),  32'h5A);
            check($sformatf("stall%0d_cmd_ready", i), 32'(cmd_ready), 32'd0);
            check($sformatf("stall%0d_ui_in", i),     32'(pin_ui_in), 32'h5A);
            step(1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        check("stall_cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("stall_cmd_ignored",     32'(pin_ui_in), 32'h5A);

        // ---- 16 back-to-back echo commands --------------------------------
        rsp_ready = 1'b1;
        tx        = 0;
        rx        = 0;
        cmd_valid = 1'b1;
        cmd_data  = 8'h00;
        for (int c = 0; c < 400 && rx < 16; c++) begin
            fire_cmd = cmd_valid && cmd_ready;
            fire_rsp = rsp_valid && rsp_ready;
            if (fire_rsp) begin
                check($sformatf("b2b%0d_data", rx), 32'(rsp_data), 32'(rx));
                rx++;
            end
            step(1);
            if (fire_rsp) begin
                check($sformatf("b2b%0d_ready_next", rx - 1), 32'(cmd_ready), 32'd1);
            end
            if (fire_cmd) begin
                tx++;
                cmd_valid = (tx < 16);
                cmd_data  = 8'(tx);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check("b2b_rsp_count", 32'(rx), 32'd16);
        check("b2b_cmd_count", 32'(tx), 32'd16);

        // ---- Ack driven but not enabled ----------------------------------
        comb_ack = 1'b0;
        echo     = 1'b0;
        tb_ack   = 1'b1;
        tb_oe    = 1'b0;
        send_cmd("noe", 8'hB4);
        step(1);
        check("noe_req_hi", 32'(pin_uio_in), 32'h01);
`ifdef TT_PIN_HOST_TIMEOUT_EN
        wait_rsp(TIMEOUT + 20, cyc);
        check("noe_timeout_cycles", 32'(cyc),        32'(TIMEOUT));
        check("noe_timeout_err",    32'(rsp_err),    32'd1);
        check("noe_timeout_data",   32'(rsp_data),   32'hFF);
        check("noe_timeout_req_lo", 32'(pin_uio_in), 32'h00);
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        send_cmd("noe2", 8'hC3);
        step(1);
        check("noe2_req_hi", 32'(pin_uio_in), 32'h01);
`else
        step(40);
        check("noe_no_rsp",     32'(rsp_valid),  32'd0);
        check("noe_stuck_req",  32'(pin_uio_in), 32'h01);
        check("noe_busy",       32'(busy),       32'd1);
        check("noe_cmd_ready",  32'(cmd_ready),  32'd0);
`endif

        // ---- rst pulse while in REQ --------------------------------------
        rst = 1'b1;
        #1;
        check("abort_req_async", 32'(pin_uio_in), 32'h00);
        check("abort_rst_n",     32'(pin_rst_n),  32'd0);
        check("abort_ena",       32'(pin_ena),    32'd0);
        check("abort_rsp_valid", 32'(rsp_valid),  32'd0);
        check("abort_busy",      32'(busy),       32'd1);
        tb_ack = 1'b0;
        tb_oe  = 1'b1;
        step(2);
        reset_release("rerst");

        // ---- One transaction after the re-reset --------------------------
        comb_ack = 1'b1;
        echo     = 1'b1;
        send_cmd("post", 8'h96);
        wait_rsp(40, cyc);
        check("post_rsp_valid", 32'(rsp_valid), 32'd1);
        check("post_rsp_data",  32'(rsp_data),  32'h96);
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
